// File: rtl/fact_pkg.sv
// Shared types and default sizing for the factorial-unit scheduler.
package fact_pkg;

    localparam int NREQ_DEF       = 2;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_WIDTH_DEF    = 4;
    localparam int N_MAX_DEF      = 12;
    localparam int TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/fact_sched_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    always_comb begin : pick
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int off = NREQ - 1; off >= 0; off--) begin
            j = (int'(ptr) + off) % NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one factorial unit between NREQ requesters.
// Handshake: a requester holds req/req_n until its one-cycle ack, then drops req.
module fact_sched
    import fact_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_WIDTH    = N_WIDTH_DEF,
    parameter int N_MAX      = N_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*N_WIDTH-1:0]   req_n,
    output logic [NREQ-1:0]           ack,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic                      rsp_tmo,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      fu_go,
    output logic [N_WIDTH-1:0]        fu_n,
    output logic                      fu_clr,
    input  logic                      fu_done,
    input  logic                      fu_err,
    input  logic [DATA_WIDTH-1:0]     fu_result,
    output state_t                    dbg_state
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    state_t                state_q, state_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_tmo_q, rsp_tmo_d;
    logic                  busy_q, busy_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic                  fu_go_q, fu_go_d;
    logic [N_WIDTH-1:0]    fu_n_q, fu_n_d;
    logic                  fu_clr_q, fu_clr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic [N_WIDTH-1:0]    pick_n;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_n = req_n[int'(pick_idx)*N_WIDTH +: N_WIDTH];

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        rsp_tmo_d  = 1'b0;
        fu_go_d    = 1'b0;
        fu_clr_d   = 1'b0;
        fu_n_d     = fu_n_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    // Out-of-range operands are answered directly, the unit never sees them.
                    if (int'(pick_n) > N_MAX) begin
                        state_d           = ST_RESP;
                        ack_d[pick_idx]   = 1'b1;
                        rsp_err_d         = 1'b1;
                    end else begin
                        state_d = ST_LAUNCH;
                        fu_go_d = 1'b1;
                        fu_n_d  = pick_n;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over the timeout when both land in the same cycle.
                if (fu_done) begin
                    state_d          = ST_RESP;
                    ack_d[grant_q]   = 1'b1;
                    rsp_err_d        = fu_err;
                    rsp_data_d       = fu_err ? '0 : fu_result;
                    fu_n_d           = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d          = ST_RESP;
                    ack_d[grant_q]   = 1'b1;
                    rsp_err_d        = 1'b1;
                    rsp_tmo_d        = 1'b1;
                    fu_clr_d         = 1'b1;
                    fu_n_d           = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_tmo_q  <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            ptr_q      <= '0;
            fu_go_q    <= 1'b0;
            fu_n_q     <= '0;
            fu_clr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_tmo_q  <= rsp_tmo_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            fu_go_q    <= fu_go_d;
            fu_n_q     <= fu_n_d;
            fu_clr_q   <= fu_clr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign fu_go     = fu_go_q;
    assign fu_n      = fu_n_q;
    assign fu_clr    = fu_clr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched with a behavioural factorial unit.
module tb_fact_sched;
    import fact_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req = '0;
    logic [7:0]  req_n = '0;
    logic [1:0]  ack;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        busy;
    logic [0:0]  grant_id;
    logic        fu_go;
    logic [3:0]  fu_n;
    logic        fu_clr;
    logic        fu_done = 1'b0;
    logic        fu_err = 1'b0;
    logic [31:0] fu_result = '0;
    state_t      dbg_state;

    int n_pass = 0;
    int n_chk  = 0;
    int go_cnt = 0;
    int clr_cnt = 0;
    int ack_cnt = 0;

    int model_delay = 3;
    bit model_hang = 1'b0;
    bit model_err = 1'b0;
    int cd = 0;

    always #5 CLK = ~CLK;

    fact_sched #(
        .NREQ(2), .DATA_WIDTH(32), .N_WIDTH(4), .N_MAX(12), .TIMEOUT(64)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_n(req_n), .ack(ack),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo), .busy(busy),
        .grant_id(grant_id), .fu_go(fu_go), .fu_n(fu_n), .fu_clr(fu_clr),
        .fu_done(fu_done), .fu_err(fu_err), .fu_result(fu_result),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    // Factorial unit model: done model_delay cycles after GO, unless hung.
    always @(negedge CLK) begin
        fu_done   = 1'b0;
        fu_err    = 1'b0;
        fu_result = '0;
        if (!RST || fu_clr) begin
            cd = 0;
        end else if (fu_go) begin
            if (!model_hang) cd = model_delay;
        end else if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                fu_done   = 1'b1;
                fu_err    = model_err;
                fu_result = model_err ? 32'hDEADBEEF : fact(fu_n);
            end
        end
    end

    always @(negedge CLK) begin
        if (fu_go) go_cnt++;
        if (fu_clr) clr_cnt++;
        if (ack != 2'b00) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},   32'(ack), 32'd0);
        chk({tag, "_data"},  rsp_data, 32'd0);
        chk({tag, "_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_tmo"},   32'(rsp_tmo), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_gid"},   32'(grant_id), 32'd0);
        chk({tag, "_go"},    32'(fu_go), 32'd0);
        chk({tag, "_fun"},   32'(fu_n), 32'd0);
        chk({tag, "_clr"},   32'(fu_clr), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // Wait for ack (bounded), check the response, then drop the served request.
    task automatic run_job(input string tag, input logic [1:0] e_ack, input logic [31:0] e_data,
                           input logic e_err, input logic e_tmo, input int e_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (ack == 2'b00 && lat < 200);
        chk({tag, "_lat"},  32'(lat), 32'(e_lat));
        chk({tag, "_ack"},  32'(ack), 32'(e_ack));
        chk({tag, "_data"}, rsp_data, e_data);
        chk({tag, "_err"},  32'(rsp_err), 32'(e_err));
        chk({tag, "_tmo"},  32'(rsp_tmo), 32'(e_tmo));
        req = req & ~ack;
    endtask

    initial begin
        #3 RST = 1'b0;
        #1 chk_zero("rst");
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // Single job
        @(negedge CLK);
        req = 2'b01; req_n[3:0] = 4'd5;
        run_job("t1", 2'b01, 32'd120, 1'b0, 1'b0, 5);
        chk("t1_go_cnt", 32'(go_cnt), 32'd1);
        @(negedge CLK);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_data", rsp_data, 32'd0);

        // Reset to bring the pointer back to 0
        #2 RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;

        // Contention
        @(negedge CLK);
        req = 2'b11; req_n = {4'd4, 4'd3};
        run_job("t2a", 2'b01, 32'd6, 1'b0, 1'b0, 5);
        run_job("t2b", 2'b10, 32'd24, 1'b0, 1'b0, 6);
        @(negedge CLK);
        req = 2'b11; req_n = {4'd2, 4'd6};
        run_job("t2c", 2'b01, 32'd720, 1'b0, 1'b0, 5);
        run_job("t2d", 2'b10, 32'd2, 1'b0, 1'b0, 6);

        // Range reject, then the largest accepted operand
        @(negedge CLK);
        req = 2'b01; req_n[3:0] = 4'd13;
        run_job("t3_rej", 2'b01, 32'd0, 1'b1, 1'b0, 1);
        chk("t3_go_cnt", 32'(go_cnt), 32'd5);
        @(negedge CLK);
        req = 2'b10; req_n[7:4] = 4'd12;
        run_job("t3_max", 2'b10, 32'd479001600, 1'b0, 1'b0, 5);

        // Overflow from the unit
        @(negedge CLK);
        model_err = 1'b1;
        req = 2'b01; req_n[3:0] = 4'd7;
        run_job("t4", 2'b01, 32'd0, 1'b1, 1'b0, 5);
        model_err = 1'b0;

        // Done on the last WAIT cycle beats the timeout
        @(negedge CLK);
        model_delay = 64;
        req = 2'b10; req_n[7:4] = 4'd5;
        run_job("t5_edge", 2'b10, 32'd120, 1'b0, 1'b0, 66);
        chk("t5_edge_clr_cnt", 32'(clr_cnt), 32'd0);
        model_delay = 3;

        // Hung unit
        @(negedge CLK);
        model_hang = 1'b1;
        req = 2'b01; req_n[3:0] = 4'd3;
        run_job("t5_tmo", 2'b01, 32'd0, 1'b1, 1'b1, 66);
        chk("t5_tmo_clr", 32'(fu_clr), 32'd1);
        model_hang = 1'b0;
        @(negedge CLK);
        chk("t5_clr_cnt", 32'(clr_cnt), 32'd1);
        req = 2'b01; req_n[3:0] = 4'd4;
        run_job("t5_after", 2'b01, 32'd24, 1'b0, 1'b0, 5);

        // Reset in the middle of WAIT
        @(negedge CLK);
        model_hang = 1'b1;
        req = 2'b10; req_n[7:4] = 4'd6;
        repeat (4) @(negedge CLK);
        chk("t6_state", 32'(dbg_state), 32'(ST_WAIT));
        chk("t6_fun", 32'(fu_n), 32'd6);
        chk("t6_gid", 32'(grant_id), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        #2 RST = 1'b0;
        #1 chk_zero("t6_rst");
        req = 2'b00;
        model_hang = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("t6_noack", 32'(ack), 32'd0);
        end
        RST = 1'b1;
        @(negedge CLK);
        req = 2'b11; req_n = {4'd3, 4'd2};
        run_job("t6a", 2'b01, 32'd2, 1'b0, 1'b0, 5);
        run_job("t6b", 2'b10, 32'd6, 1'b0, 1'b0, 6);

        @(negedge CLK);
        chk("end_go_cnt", 32'(go_cnt), 32'd13);
        chk("end_clr_cnt", 32'(clr_cnt), 32'd1);
        chk("end_ack_cnt", 32'(ack_cnt), 32'd13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
